// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: grants one requester at a time a burst of up to
// MAX_BURST beats into a FIFO write port, with a pass-through data mux.
module fifo_wr_arbiter #(
  parameter int DSIZE     = 8,
  parameter int NREQ      = 4,
  parameter int MAX_BURST = 4
) (
  input  logic                  wclk,
  input  logic                  wrst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*DSIZE-1:0] req_data,
  output logic [NREQ-1:0]       gnt,
  input  logic                  wfull,
  output logic                  winc,
  output logic [DSIZE-1:0]      wdata,
  output logic                  busy,
  output logic [15:0]           wr_count
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic {IDLE = 1'b0, GRANT = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [PW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]     gidx_q, gidx_d;
  logic [3:0]        beat_q, beat_d;
  logic [15:0]       wr_count_q, wr_count_d;

  logic [DSIZE-1:0]  slice [NREQ];
  logic [2*NREQ-1:0] req_dbl;
  logic [NREQ-1:0]   req_rot;
  logic [PW-1:0]     off, sel, ptr_inc;
  logic [PW:0]       sel_sum, ptr_sum;
  logic              req_g;

  always_comb begin
    for (int k = 0; k < NREQ; k++) begin
      slice[k] = req_data[k*DSIZE +: DSIZE];
    end
  end

  // Rotate requests so bit 0 is rr_ptr; the lowest set bit is the winner.
  always_comb begin
    req_dbl = {req, req} >> rr_ptr_q;
    req_rot = req_dbl[NREQ-1:0];
    off     = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      if (req_rot[k]) off = PW'(k);
    end
    sel_sum = {1'b0, rr_ptr_q} + {1'b0, off};
    if (sel_sum >= (PW+1)'(NREQ)) sel_sum = sel_sum - (PW+1)'(NREQ);
    sel = sel_sum[PW-1:0];
  end

  always_comb begin
    ptr_sum = {1'b0, gidx_q} + (PW+1)'(1);
    ptr_inc = (ptr_sum == (PW+1)'(NREQ)) ? '0 : ptr_sum[PW-1:0];
  end

  assign req_g    = req[gidx_q];
  assign winc     = (state_q == GRANT) & req_g & ~wfull;
  assign wdata    = winc ? slice[gidx_q] : '0;
  assign busy     = (state_q == GRANT);
  assign gnt      = gnt_q;
  assign wr_count = wr_count_q;

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    rr_ptr_d   = rr_ptr_q;
    gidx_d     = gidx_q;
    beat_d     = beat_q;
    wr_count_d = wr_count_q + {15'd0, winc};
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          gnt_d   = {{(NREQ-1){1'b0}}, 1'b1} << sel;
          gidx_d  = sel;
          beat_d  = '0;
        end
      end
      GRANT: begin
        if (!req_g) begin
          state_d  = IDLE;
          gnt_d    = '0;
          rr_ptr_d = ptr_inc;
        end else if (winc) begin
          beat_d = beat_q + 4'd1;
          if (beat_d == 4'(MAX_BURST)) begin
            state_d  = IDLE;
            gnt_d    = '0;
            rr_ptr_d = ptr_inc;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      rr_ptr_q   <= '0;
      gidx_q     <= '0;
      beat_q     <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      rr_ptr_q   <= rr_ptr_d;
      gidx_q     <= gidx_d;
      beat_q     <= beat_d;
      wr_count_q <= wr_count_d;
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: vector table, directed corner sequences, random
// traffic against a behavioural arbiter model, and a counter-wrap instance.
module tb_fifo_wr_arbiter;
  localparam int DW = 8;
  localparam int NR = 4;
  localparam int MB = 4;

  logic wclk = 1'b0;
  always #5 wclk = ~wclk;

  logic              wrst;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  req_data;
  logic [NR-1:0]     gnt;
  logic              wfull, winc, busy;
  logic [DW-1:0]     wdata;
  logic [15:0]       wr_count;

  fifo_wr_arbiter #(.DSIZE(DW), .NREQ(NR), .MAX_BURST(MB)) dut (
    .wclk(wclk), .wrst(wrst), .req(req), .req_data(req_data), .gnt(gnt),
    .wfull(wfull), .winc(winc), .wdata(wdata), .busy(busy), .wr_count(wr_count));

  logic        rst2, winc2, busy2, done2;
  logic [1:0]  req2, gnt2;
  logic [15:0] req_data2, wr_count2;
  logic [7:0]  wdata2;
  logic        wfull2;

  fifo_wr_arbiter #(.DSIZE(8), .NREQ(2), .MAX_BURST(15)) dut2 (
    .wclk(wclk), .wrst(rst2), .req(req2), .req_data(req_data2), .gnt(gnt2),
    .wfull(wfull2), .winc(winc2), .wdata(wdata2), .busy(busy2), .wr_count(wr_count2));

  int n_checks = 0;
  int n_errs   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: m_g is the granted requester, -1 when none.
  int m_g, m_beats, m_ptr, m_cnt;

  task automatic model_reset();
    m_g = -1; m_beats = 0; m_ptr = 0; m_cnt = 0;
  endtask

  function automatic logic [DW-1:0] dslice(input int i);
    return req_data[i*DW +: DW];
  endfunction

  task automatic step();
    logic e_winc;
    @(negedge wclk);
    e_winc = (m_g >= 0) && req[m_g] && !wfull;
    chk("gnt",       32'(gnt),      (m_g >= 0) ? (32'd1 << m_g) : 32'd0);
    chk("busy",      32'(busy),     32'(m_g >= 0));
    chk("winc",      32'(winc),     32'(e_winc));
    chk("wdata",     32'(wdata),    e_winc ? 32'(dslice(m_g)) : 32'd0);
    chk("wr_count",  32'(wr_count), 32'(m_cnt));
    chk("onehot0",   32'($onehot0(gnt)), 32'd1);
    chk("winc_full", 32'(winc & wfull), 32'd0);
    if (m_g < 0) begin
      if (req != '0) begin
        for (int k = 0; k < NR; k++) begin
          if (req[(m_ptr + k) % NR]) begin
            m_g = (m_ptr + k) % NR;
            break;
          end
        end
        m_beats = 0;
      end
    end else if (!req[m_g]) begin
      m_ptr = (m_g + 1) % NR; m_g = -1;
    end else if (!wfull) begin
      m_cnt = (m_cnt + 1) % 65536;
      m_beats++;
      if (m_beats == MB) begin
        m_ptr = (m_g + 1) % NR; m_g = -1;
      end
    end
    @(posedge wclk); #1;
  endtask

  task automatic do_reset();
    wrst = 1'b1;
    @(posedge wclk); #1;
    wrst = 1'b0;
    model_reset();
  endtask

  typedef struct {
    logic [NR-1:0] req;
    logic          wfull;
    logic [DW-1:0] d2;
    logic [NR-1:0] e_gnt;
    logic          e_winc;
    logic [DW-1:0] e_wdata;
  } vec_t;

  vec_t tbl [10];

  function automatic int beats_after(input int n);
    return 15 * (n / 16) + ((n % 16) > 0 ? (n % 16) - 1 : 0);
  endfunction

  // Wrap instance: requester 0 holds req, 15 beats every 16 cycles.
  initial begin
    done2 = 1'b0; rst2 = 1'b1; req2 = '0; wfull2 = 1'b0; req_data2 = 16'h5AC3;
    @(posedge wclk); #1;
    rst2 = 1'b0; req2 = 2'b01;
    for (int n = 1; n <= 69907; n++) begin
      @(posedge wclk); #1;
      if (n == 2 || n == 16 || n == 17 || n == 18 || n == 69903 || n == 69907)
        chk("wrap_cnt", 32'(wr_count2), 32'(beats_after(n) & 16'hFFFF));
    end
    req2 = '0;
    done2 = 1'b1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{4'b0100, 1'b0, 8'hA0, 4'b0000, 1'b0, 8'h00};
    tbl[1] = '{4'b0100, 1'b0, 8'hA0, 4'b0100, 1'b1, 8'hA0};
    tbl[2] = '{4'b0100, 1'b0, 8'hA1, 4'b0100, 1'b1, 8'hA1};
    tbl[3] = '{4'b0100, 1'b0, 8'hA2, 4'b0100, 1'b1, 8'hA2};
    tbl[4] = '{4'b0100, 1'b0, 8'hA3, 4'b0100, 1'b1, 8'hA3};
    tbl[5] = '{4'b0100, 1'b0, 8'hA4, 4'b0000, 1'b0, 8'h00};
    tbl[6] = '{4'b0100, 1'b0, 8'hA4, 4'b0100, 1'b1, 8'hA4};
    tbl[7] = '{4'b0100, 1'b0, 8'hA5, 4'b0100, 1'b1, 8'hA5};
    tbl[8] = '{4'b0000, 1'b0, 8'h00, 4'b0100, 1'b0, 8'h00};
    tbl[9] = '{4'b0000, 1'b0, 8'h00, 4'b0000, 1'b0, 8'h00};

    wrst = 1'b1; req = '0; wfull = 1'b0; req_data = 32'h44_33_22_11;
    model_reset();
    #1;
    chk("rst_gnt",   32'(gnt),      0);
    chk("rst_busy",  32'(busy),     0);
    chk("rst_winc",  32'(winc),     0);
    chk("rst_wdata", 32'(wdata),    0);
    chk("rst_cnt",   32'(wr_count), 0);
    @(posedge wclk); #1;
    wrst = 1'b0;

    // Single requester burst split by the MAX_BURST limit.
    for (int i = 0; i < 10; i++) begin
      req = tbl[i].req; wfull = tbl[i].wfull;
      req_data[2*DW +: DW] = tbl[i].d2;
      #3;
      chk("tbl_gnt",   32'(gnt),   32'(tbl[i].e_gnt));
      chk("tbl_winc",  32'(winc),  32'(tbl[i].e_winc));
      chk("tbl_wdata", 32'(wdata), 32'(tbl[i].e_wdata));
      step();
    end
    chk("tbl_count", 32'(wr_count), 6);

    // Round robin with all requesters active.
    do_reset();
    req = 4'b1111; req_data = 32'hD3_C2_B1_A0;
    for (int k = 0; k < 5; k++) begin
      #3 chk("rr_idle", 32'(gnt), 0);
      step();
      for (int b = 0; b < 4; b++) begin
        #3;
        chk("rr_gnt",  32'(gnt),  32'd1 << (k % 4));
        chk("rr_winc", 32'(winc), 1);
        step();
      end
    end

    // FIFO full stall mid-burst.
    req = 4'b0010;
    step(); step(); step();
    wfull = 1'b1;
    repeat (5) begin
      #3;
      chk("stall_winc", 32'(winc), 0);
      chk("stall_gnt",  32'(gnt),  32'b0010);
      step();
    end
    wfull = 1'b0;
    repeat (2) begin
      #3 chk("stall_resume", 32'(winc), 1);
      step();
    end
    #3 chk("stall_release", 32'(gnt), 0);
    req = '0;
    step();

    // Early drop with requesters 0 and 3 waiting.
    do_reset();
    req = 4'b1010;
    step();
    #3;
    chk("drop_gnt1", 32'(gnt),  32'b0010);
    chk("drop_beat", 32'(winc), 1);
    step();
    req = 4'b1001;
    #3;
    chk("drop_hold", 32'(gnt),  32'b0010);
    chk("drop_winc", 32'(winc), 0);
    step();
    #3 chk("drop_idle", 32'(gnt), 0);
    step();
    #3 chk("drop_next", 32'(gnt), 32'b1000);
    req = '0;
    step(); step();

    // Asynchronous reset during the third beat.
    req = 4'b0001;
    step(); step(); step();
    #2 chk("rst_pre_winc", 32'(winc), 1);
    wrst = 1'b1;
    #1;
    chk("arst_gnt",   32'(gnt),      0);
    chk("arst_winc",  32'(winc),     0);
    chk("arst_busy",  32'(busy),     0);
    chk("arst_wdata", 32'(wdata),    0);
    chk("arst_cnt",   32'(wr_count), 0);
    @(posedge wclk); #1;
    wrst = 1'b0;
    model_reset();
    req = 4'b1010;
    step();
    #3 chk("arst_regrant", 32'(gnt), 32'b0010);
    step();
    req = '0;
    step(); step();

    // Random traffic against the model.
    repeat (400) begin
      req      = NR'($urandom);
      wfull    = ($urandom % 4) == 0;
      req_data = $urandom;
      step();
    end
    req = '0; wfull = 1'b0;

    wait (done2);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
